// File: rtl/a_rd_sched_x4_ram.sv
`default_nettype none
// ============================================================================
// Module   : a_rd_sched_x4_ram
// Brief    : Burst read scheduler for the four-bank RAM read crossbar; the
//            optional dv/beat alignment check is enabled by A_RD_SCHED_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module a_rd_sched_x4_ram #(
  parameter int ADDR_W  = 10,
  parameter int RAM_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_bank_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [3:0]        cmd_len_i,
  output logic [3:0]        rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [2:0]        ctrl_o,
  input  logic              xbar_dv_i,
  output logic              done_o,
  output logic              busy_o,
  output logic              err_o
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_bank, w_bank_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [3:0]        r_rem, w_rem_nxt;
  logic              w_issue, w_last, w_accept, w_exp;

  // Beat pipeline: stage RAM_LAT-1 lines up with data leaving the RAM.
  logic [RAM_LAT-1:0] r_pv, r_pl;
  logic [1:0]         r_pb [RAM_LAT];

  function automatic logic [2:0] f_ctrl(input logic [1:0] bank);
    case (bank)
      2'd0:    f_ctrl = 3'b000;
      2'd1:    f_ctrl = 3'b001;
      2'd2:    f_ctrl = 3'b010;
      default: f_ctrl = 3'b100;
    endcase
  endfunction

  assign w_issue     = (r_state == BURST);
  assign w_last      = (r_rem == 4'd0);
  assign cmd_ready_o = ~rst_i & (~w_issue | w_last);
  assign w_accept    = cmd_valid_i & cmd_ready_o;

  always_comb begin
    w_state_nxt = r_state;
    w_bank_nxt  = r_bank;
    w_addr_nxt  = r_addr;
    w_rem_nxt   = r_rem;
    if (w_issue) begin
      w_addr_nxt = r_addr + ADDR_W'(1);
      w_rem_nxt  = r_rem - 4'd1;
      if (w_last) begin
        w_state_nxt = IDLE;
      end
    end
    // An accept on the last beat overrides the return to IDLE: no gap.
    if (w_accept) begin
      w_state_nxt = BURST;
      w_bank_nxt  = cmd_bank_i;
      w_addr_nxt  = cmd_addr_i;
      w_rem_nxt   = cmd_len_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_bank  <= 2'd0;
      r_addr  <= '0;
      r_rem   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_bank  <= w_bank_nxt;
      r_addr  <= w_addr_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pv <= '0;
      r_pl <= '0;
      for (int i = 0; i < RAM_LAT; i++) begin
        r_pb[i] <= 2'd0;
      end
    end else begin
      r_pv[0] <= w_issue;
      r_pl[0] <= w_issue & w_last;
      r_pb[0] <= r_bank;
      for (int i = 1; i < RAM_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pl[i] <= r_pl[i-1];
        r_pb[i] <= r_pb[i-1];
      end
    end
  end

  assign w_exp     = r_pv[RAM_LAT-1];
  assign rd_en_o   = w_issue ? (4'b0001 << r_bank) : 4'b0000;
  assign rd_addr_o = r_addr;
  assign ctrl_o    = w_exp ? f_ctrl(r_pb[RAM_LAT-1]) : 3'b000;
  assign done_o    = w_exp & r_pl[RAM_LAT-1];
  assign busy_o    = w_issue | (|r_pv);

`ifdef A_RD_SCHED_ERR_EN
  logic r_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (xbar_dv_i != w_exp) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  logic w_unused_dv;

  assign w_unused_dv = xbar_dv_i;
  assign err_o       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_a_rd_sched_x4_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_a_rd_sched_x4_ram
// Brief    : Scoreboard bench for a_rd_sched_x4_ram (directed + random bursts).
// Revision : 1.0 - initial release
// ============================================================================
module tb_a_rd_sched_x4_ram;
  localparam int ADDR_W  = 10;
  localparam int RAM_LAT = 2;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              cmd_valid_i = 1'b0;
  logic              cmd_ready_o;
  logic [1:0]        cmd_bank_i = 2'd0;
  logic [ADDR_W-1:0] cmd_addr_i = '0;
  logic [3:0]        cmd_len_i = 4'd0;
  logic [3:0]        rd_en_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic [2:0]        ctrl_o;
  logic              xbar_dv_i = 1'b0;
  logic              done_o;
  logic              busy_o;
  logic              err_o;

  typedef struct {
    int                cyc;
    int                acc;
    logic [1:0]        bank;
    logic [ADDR_W-1:0] addr;
    logic              last;
  } beat_t;

  beat_t iq[$];
  beat_t rq[$];
  int    cyc = 0;
  int    n_chk = 0;
  int    n_err = 0;
  bit    rst_s = 1'b0;
  bit    inj = 1'b0;
  logic  err_exp = 1'b0;

  a_rd_sched_x4_ram #(.ADDR_W(ADDR_W), .RAM_LAT(RAM_LAT)) dut (
    .clk_i(clk), .rst_i(rst_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_bank_i(cmd_bank_i), .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
    .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .ctrl_o(ctrl_o), .xbar_dv_i(xbar_dv_i),
    .done_o(done_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_s <= rst_i;
  end

  function automatic logic [2:0] sel_code(input logic [1:0] b);
    logic [2:0] tbl [4];
    tbl[0] = 3'b000; tbl[1] = 3'b001; tbl[2] = 3'b010; tbl[3] = 3'b100;
    return tbl[b];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Crossbar model: returns dv exactly when a beat is due, unless an error is injected.
  initial forever begin
    @(posedge clk);
    #2;
    xbar_dv_i = (rq.size() > 0 && rq[0].cyc == cyc) && !inj;
  end

  task automatic mon();
    bit    pend = 1'b0;
    bit    dv;
    bit    busy_e;
    beat_t b;
    foreach (iq[i]) if (iq[i].acc < cyc && iq[i].cyc > cyc) pend = 1'b1;
    chk("ready", cmd_ready_o, !rst_i && !pend);
    busy_e = (iq.size() > 0 && iq[0].cyc <= cyc) || (rq.size() > 0 && rq[0].cyc - RAM_LAT <= cyc);
    chk("busy", busy_o, busy_e);
    if (iq.size() > 0 && iq[0].cyc == cyc) begin
      b = iq.pop_front();
      chk("rd_en", rd_en_o, 32'(4'b0001 << b.bank));
      chk("rd_addr", rd_addr_o, b.addr);
    end else begin
      chk("rd_en_idle", rd_en_o, 0);
    end
    dv = (rq.size() > 0 && rq[0].cyc == cyc);
    if (dv) begin
      b = rq.pop_front();
      chk("ctrl", ctrl_o, sel_code(b.bank));
      chk("done", done_o, b.last);
    end else begin
      chk("ctrl_idle", ctrl_o, 0);
      chk("done_idle", done_o, 0);
    end
    if (rst_s) err_exp = 1'b0;
    chk("err", err_o, err_exp);
`ifdef A_RD_SCHED_ERR_EN
    if (!rst_i && xbar_dv_i != dv) err_exp = 1'b1;
`endif
  endtask

  initial forever begin
    @(negedge clk);
    mon();
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at 1 time unit after a rising edge; returns at the same phase of the
  // cycle carrying the first beat of the accepted burst.
  task automatic send(input logic [1:0] b, input logic [ADDR_W-1:0] a, input logic [3:0] l);
    int  w = 0;
    bit  fin = 1'b0;
    beat_t e;
    cmd_valid_i = 1'b1;
    cmd_bank_i  = b;
    cmd_addr_i  = a;
    cmd_len_i   = l;
    while (!fin) begin
      #1;
      if (cmd_ready_o) begin
        for (int k = 0; k <= int'(l); k++) begin
          e.acc  = cyc;
          e.cyc  = cyc + 1 + k;
          e.bank = b;
          e.addr = ADDR_W'((int'(a) + k) % (1 << ADDR_W));
          e.last = (k == int'(l));
          iq.push_back(e);
          e.cyc  = e.cyc + RAM_LAT;
          rq.push_back(e);
        end
        fin = 1'b1;
      end else if (w >= 200) begin
        n_chk++;
        n_err++;
        $display("FAIL accept_timeout cycle %0d: got ready=0 expected ready=1", cyc);
        fin = 1'b1;
      end else begin
        w++;
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
    cmd_bank_i  = 2'($urandom);
    cmd_addr_i  = ADDR_W'($urandom);
    cmd_len_i   = 4'($urandom);
  endtask

  task automatic rst_pulse(input int h);
    rst_i = 1'b1;
    while (iq.size() > 0 && iq[$].cyc > cyc) void'(iq.pop_back());
    while (rq.size() > 0 && rq[$].cyc > cyc) void'(rq.pop_back());
    idle(h);
    rst_i = 1'b0;
  endtask

  initial begin
    int g;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    idle(1);
    send(2'd2, 10'h010, 4'd3);
    idle(8);
    send(2'd0, 10'h100, 4'd1);
    send(2'd3, 10'h200, 4'd0);
    idle(6);
    send(2'd1, 10'h3FE, 4'd3);
    idle(7);
    send(2'd3, 10'h040, 4'd15);
    idle(5);
    rst_pulse(1);
    send(2'd0, 10'h055, 4'd2);
    idle(6);
    send(2'd2, 10'h000, 4'd15);
    idle(RAM_LAT + 18);
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send(2'($urandom), ADDR_W'($urandom), 4'($urandom));
      if ($urandom_range(0, 14) == 0) begin
        idle($urandom_range(0, 4));
        rst_pulse($urandom_range(1, 2));
      end
    end
    g = 0;
    while ((iq.size() > 0 || rq.size() > 0) && g < 200) begin
      idle(1);
      g++;
    end
    if (iq.size() > 0 || rq.size() > 0) begin
      n_chk++;
      n_err++;
      $display("FAIL drain_timeout cycle %0d: got %0d beats pending expected 0", cyc, iq.size() + rq.size());
    end
    idle(2);
`ifdef A_RD_SCHED_ERR_EN
    send(2'd1, 10'h123, 4'd3);
    idle(RAM_LAT);
    inj = 1'b1;
    idle(1);
    inj = 1'b0;
    idle(10);
`endif
    idle(3);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
